// File: rtl/ping_target_gen.sv
// Target generator for the ping game: issues LFSR targets to the equality comparator and scores hits and misses.
// Optional feature macro: PING_SPEEDUP_EN (each hit shrinks the armed window down to a floor).
module ping_target_gen #(
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned GAP    = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        eq,
  output logic [15:0] target,
  output logic        valid,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  score,
  output logic        busy
);

  localparam int unsigned TW = $clog2(WINDOW + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2,
    S_COOL  = 2'd3
  } state_t;

  // Galois right-shift LFSR step; a non-zero state never maps to zero
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_lfsr, w_lfsr_nxt;
  logic [15:0]     r_target, w_target_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic [7:0]      r_score, w_score_nxt;
  logic            r_hit, w_hit_nxt;
  logic            r_miss, w_miss_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_busy, w_busy_nxt;
  logic [15:0]     w_lfsr_adv;
  logic [TW-1:0]   w_win_last;

  assign w_lfsr_adv = lfsr_step(r_lfsr);

`ifdef PING_SPEEDUP_EN
  localparam int unsigned FLOOR = (WINDOW < 64) ? WINDOW : 64;
  logic [TW-1:0] r_win, w_win_nxt, w_win_dec;

  assign w_win_last = r_win - TW'(1);

  // Window after a hit: shrink by 16 but never below the floor
  always_comb begin
    if (32'(r_win) >= FLOOR + 32'd16) begin
      w_win_dec = TW'(32'(r_win) - 32'd16);
    end else begin
      w_win_dec = TW'(FLOOR);
    end
  end

  // Active window register, restored on every accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= TW'(WINDOW);
    end else begin
      r_win <= w_win_nxt;
    end
  end
`else
  assign w_win_last = TW'(WINDOW - 1);
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_target_nxt = r_target;
    w_timer_nxt  = r_timer;
    w_gap_nxt    = r_gap;
    w_score_nxt  = r_score;
    w_hit_nxt    = 1'b0;
    w_miss_nxt   = 1'b0;
`ifdef PING_SPEEDUP_EN
    w_win_nxt    = r_win;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_score_nxt = 8'd0;
          w_state_nxt = S_LOAD;
`ifdef PING_SPEEDUP_EN
          w_win_nxt   = TW'(WINDOW);
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_lfsr_nxt   = w_lfsr_adv;
        w_target_nxt = w_lfsr_adv;
        w_timer_nxt  = '0;
        w_state_nxt  = S_ARMED;
      end
      S_ARMED: begin
        // eq takes priority over a coincident timeout
        if (eq) begin
          w_hit_nxt   = 1'b1;
          w_score_nxt = (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
          w_gap_nxt   = '0;
          w_state_nxt = S_COOL;
`ifdef PING_SPEEDUP_EN
          w_win_nxt   = w_win_dec;
`endif
        end else if (r_timer == w_win_last) begin
          w_miss_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_COOL: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_valid_nxt = (w_state_nxt == S_ARMED);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED_EFF;
      r_target <= 16'h0000;
      r_timer  <= '0;
      r_gap    <= '0;
      r_score  <= 8'd0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_target <= w_target_nxt;
      r_timer  <= w_timer_nxt;
      r_gap    <= w_gap_nxt;
      r_score  <= w_score_nxt;
      r_hit    <= w_hit_nxt;
      r_miss   <= w_miss_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign target = r_target;
  assign valid  = r_valid;
  assign hit    = r_hit;
  assign miss   = r_miss;
  assign score  = r_score;
  assign busy   = r_busy;

endmodule
